jk_bank_driver: RTL and testbench

- Driving end for a bank of WIDTH JK flip-flops sharing clk/rst.
- Accepts target words over a valid/ready handshake and computes per-bit J/K excitation from target vs. Q feedback.
- Drives the bank for one clock, then verifies the bank reached the target. Retries on mismatch and counts failures.
- Used as the stimulus/control side for JK register banks in larger designs and benches.

---
 rtl/jk_bank_driver.sv | 155 +++++++++++++++
 tb/tb_jk_bank_driver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_driver.sv
// jk_bank_driver
// Control side for a bank of WIDTH JK flip-flops. The driver takes a target
// word over valid/ready and works out per-bit J/K excitation from the target
// and the bank's Q feedback. It drives the bank for one clock and then checks
// that the bank reached the target. On a mismatch it re-drives up to MAX_RETRY
// times. After that it reports an error and bumps a saturating error counter.
module jk_bank_driver #(
    parameter int WIDTH       = 4,
    parameter int TOGGLE_MODE = 0,
    parameter int MAX_RETRY   = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    // Three bits are enough for retry counts 0..7.
    localparam int RW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] target_reg, target_next;
    logic [RW-1:0]    retry_reg, retry_next;
    logic [WIDTH-1:0] j_reg, j_next;
    logic [WIDTH-1:0] k_reg, k_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Excitation is computed against whichever target applies in this state.
    // In IDLE that is the word on the input port. Otherwise it is the latched
    // target, which is used for the re-drive after a failed check.
    logic [WIDTH-1:0] exc_tgt;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic             match;
    logic             retry_left;
    logic             cnt_sat;

    assign exc_tgt = (state_reg == IDLE) ? tgt_data : target_reg;

    // Per-bit excitation. A bit that already equals its target gets J=K=0.
    // This means a non-changing bit can never see J=K=1, in either mode.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
            logic diff;
            assign diff = exc_tgt[gi] ^ q_fb[gi];
            if (TOGGLE_MODE != 0) begin : g_toggle
                assign exc_j[gi] = diff;
                assign exc_k[gi] = diff;
            end else begin : g_setreset
                assign exc_j[gi] = diff &  exc_tgt[gi];
                assign exc_k[gi] = diff & ~exc_tgt[gi];
            end
        end
    endgenerate

    assign match      = (q_fb == target_reg);
    assign retry_left = (retry_reg < RW'(MAX_RETRY));
    assign cnt_sat    = &cnt_reg;

    // Ready is decoded straight from the state so the handshake has no extra latency.
    assign tgt_ready = (state_reg == IDLE);
    assign j_out     = j_reg;
    assign k_out     = k_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign err_count = cnt_reg;

    // Next-state and registered-output logic. J/K default to 0 so the bank
    // holds everywhere except the cycle after a load.
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        retry_next  = retry_reg;
        j_next      = '0;
        k_next      = '0;
        done_next   = 1'b0;
        err_next    = 1'b0;
        cnt_next    = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (tgt_valid) begin
                    target_next = tgt_data;
                    retry_next  = '0;
                    j_next      = exc_j;
                    k_next      = exc_k;
                    state_next  = DRIVE;
                end
            end
            DRIVE: begin
                // The bank samples J/K on this edge. The driver just moves on.
                state_next = CHECK;
            end
            CHECK: begin
                if (match) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (retry_left) begin
                    retry_next = retry_reg + RW'(1);
                    j_next     = exc_j;
                    k_next     = exc_k;
                    state_next = DRIVE;
                end else begin
                    err_next   = 1'b1;
                    if (!cnt_sat) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops any in-flight target at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            target_reg <= '0;
            retry_reg  <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            retry_reg  <= retry_next;
            j_reg      <= j_next;
            k_reg      <= k_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            cnt_reg    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver. It builds two driver instances: one in set/reset
// mode and one in toggle mode. Each instance drives its own 4-bit JK bank
// model, and bank 0 can have bits forced stuck at 0.
module tb_jk_bank_driver;

    logic       clk;
    logic       rst;

    logic [3:0] tgt0, tgt1;
    logic       vld0, vld1;
    logic       rdy0, rdy1;
    logic [3:0] q0, q1;
    logic [3:0] j0, k0, j1, k1;
    logic       done0, done1, err0, err1;
    logic [7:0] cnt0, cnt1;
    logic [3:0] stuck0;

    jk_bank_driver #(.WIDTH(4), .TOGGLE_MODE(0), .MAX_RETRY(2), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .tgt_data(tgt0), .tgt_valid(vld0), .tgt_ready(rdy0),
        .q_fb(q0), .j_out(j0), .k_out(k0), .done(done0), .err(err0), .err_count(cnt0)
    );

    jk_bank_driver #(.WIDTH(4), .TOGGLE_MODE(1), .MAX_RETRY(2), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .tgt_data(tgt1), .tgt_valid(vld1), .tgt_ready(rdy1),
        .q_fb(q1), .j_out(j1), .k_out(k1), .done(done1), .err(err1), .err_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Textbook JK next-state function, applied per bit.
    function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j,
                                           input logic [3:0] k);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            case ({j[i], k[i]})
                2'b00:   r[i] = q[i];
                2'b01:   r[i] = 1'b0;
                2'b10:   r[i] = 1'b1;
                default: r[i] = ~q[i];
            endcase
        end
        return r;
    endfunction

    // JK banks. These share clk/rst with the drivers. A stuck bit is held at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q0 <= '0;
        else     q0 <= jk_next(q0, j0, k0) & ~stuck0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q1 <= '0;
        else     q1 <= jk_next(q1, j1, k1);
    end

    int n_chk;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Selected instance view, so that one task can exercise either driver.
    logic       sel;
    logic [3:0] s_j, s_k, s_q;
    logic       s_rdy, s_done, s_err;
    always_comb begin
        s_j    = sel ? j1    : j0;
        s_k    = sel ? k1    : k0;
        s_q    = sel ? q1    : q0;
        s_rdy  = sel ? rdy1  : rdy0;
        s_done = sel ? done1 : done0;
        s_err  = sel ? err1  : err0;
    end

    // done and err must never be asserted together on either instance.
    always @(negedge clk) begin
        chk("done_err_excl0", 32'(done0 & err0), 0);
        chk("done_err_excl1", 32'(done1 & err1), 0);
    end

    // One complete successful transaction: the handshake, the DRIVE cycle,
    // the CHECK cycle, and the done pulse followed by its clear. Ready is low
    // for the DRIVE and CHECK cycles only.
    task automatic send(input logic s, input logic [3:0] t, input logic [3:0] ej,
                        input logic [3:0] ek, input logic [3:0] eq);
        sel = s;
        #0;
        chk("ready_before", 32'(s_rdy), 1);
        if (s) begin tgt1 = t; vld1 = 1'b1; end
        else   begin tgt0 = t; vld0 = 1'b1; end
        tick();                                   // E0
        vld0 = 1'b0;
        vld1 = 1'b0;
        chk("j_drive", 32'(s_j), 32'(ej));
        chk("k_drive", 32'(s_k), 32'(ek));
        chk("ready_drive", 32'(s_rdy), 0);
        tick();                                   // E1
        chk("j_check", 32'(s_j), 0);
        chk("k_check", 32'(s_k), 0);
        chk("q_after", 32'(s_q), 32'(eq));
        chk("ready_check", 32'(s_rdy), 0);
        chk("done_early", 32'(s_done), 0);
        tick();                                   // E2
        chk("done_pulse", 32'(s_done), 1);
        chk("err_none", 32'(s_err), 0);
        chk("ready_back", 32'(s_rdy), 1);
        tick();
        chk("done_clear", 32'(s_done), 0);
        $display("txn dut%0d tgt=%b j=%b k=%b q=%b", s, t, ej, ek, s_q);
    endtask

    typedef struct {
        logic [3:0] tgt;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] q;
    } vec_t;

    vec_t tbl[6];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        sel    = 1'b0;
        rst    = 1'b1;
        tgt0   = '0; tgt1 = '0;
        vld0   = 1'b0; vld1 = 1'b0;
        stuck0 = '0;

        // Set/reset mode sequence. Every expected value is hand-derived from the
        // previous Q. The sequence ends at Q=0000.
        tbl[0] = '{tgt: 4'b1010, j: 4'b1010, k: 4'b0000, q: 4'b1010};
        tbl[1] = '{tgt: 4'b0110, j: 4'b0100, k: 4'b1000, q: 4'b0110};
        tbl[2] = '{tgt: 4'b0110, j: 4'b0000, k: 4'b0000, q: 4'b0110};
        tbl[3] = '{tgt: 4'b1111, j: 4'b1001, k: 4'b0000, q: 4'b1111};
        tbl[4] = '{tgt: 4'b0101, j: 4'b0000, k: 4'b1010, q: 4'b0101};
        tbl[5] = '{tgt: 4'b0000, j: 4'b0000, k: 4'b0101, q: 4'b0000};

        tick();
        tick();
        chk("rst_j", 32'(j0), 0);
        chk("rst_k", 32'(k0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_ready", 32'(rdy0), 1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            send(1'b0, tbl[i].tgt, tbl[i].j, tbl[i].k, tbl[i].q);
        end

        // Toggle mode: changing bits get J=K=1 and unchanged bits get J=K=0.
        send(1'b1, 4'b0110, 4'b0110, 4'b0110, 4'b0110);
        send(1'b1, 4'b1001, 4'b1111, 4'b1111, 4'b1001);

        // Bit 0 is stuck at 0. The driver should make three drive attempts, then pulse err.
        sel    = 1'b0;
        stuck0 = 4'b0001;
        tgt0   = 4'b0001;
        vld0   = 1'b1;
        tick();                                   // E0
        vld0 = 1'b0;
        for (int a = 0; a < 3; a++) begin
            chk("stuck_j", 32'(j0), 32'h1);
            chk("stuck_k", 32'(k0), 0);
            chk("stuck_nodone", 32'(done0), 0);
            tick();
            chk("stuck_j_clear", 32'(j0), 0);
            chk("stuck_no_err_yet", 32'(err0), 0);
            tick();
        end
        chk("stuck_err", 32'(err0), 1);
        chk("stuck_done", 32'(done0), 0);
        chk("stuck_cnt1", 32'(cnt0), 1);
        chk("stuck_ready", 32'(rdy0), 1);
        $display("txn dut0 tgt=0001 stuck bit0 err_count=%0d", cnt0);

        // Repeat the same failing transaction until the counter saturates, then once more.
        for (int n = 0; n < 255; n++) begin
            vld0 = 1'b1;
            tick();
            vld0 = 1'b0;
            repeat (6) tick();
            chk("stuck_err_rep", 32'(err0), 1);
        end
        chk("cnt_sat", 32'(cnt0), 32'hFF);
        tick();
        chk("err_clear", 32'(err0), 0);
        chk("cnt_hold", 32'(cnt0), 32'hFF);
        $display("txn dut0 saturation err_count=%0h", cnt0);
        stuck0 = '0;

        // Asynchronous reset in the middle of DRIVE.
        tgt0 = 4'b1100;
        vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        chk("pre_rst_j", 32'(j0), 32'hC);
        #2 rst = 1'b1;
        #1;
        chk("async_j", 32'(j0), 0);
        chk("async_k", 32'(k0), 0);
        chk("async_ready", 32'(rdy0), 1);
        chk("async_cnt", 32'(cnt0), 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_done", 32'(done0), 0);
            chk("post_rst_err", 32'(err0), 0);
        end
        $display("txn dut0 reset mid-drive discarded");
        send(1'b0, 4'b0110, 4'b0110, 4'b0000, 4'b0110);

        // tgt_valid is held high while tgt_data changes. Only words present
        // while ready is high should be accepted.
        tgt0 = 4'b0011;
        vld0 = 1'b1;
        tick();                                   // accept 0011
        chk("strm_j1", 32'(j0), 32'h1);
        chk("strm_k1", 32'(k0), 32'h4);
        tgt0 = 4'b1111;
        tick();
        chk("strm_q1", 32'(q0), 32'h3);
        tgt0 = 4'b0000;
        tick();
        chk("strm_done1", 32'(done0), 1);
        chk("strm_ready1", 32'(rdy0), 1);
        tgt0 = 4'b1100;
        tick();                                   // accept 1100
        chk("strm_j2", 32'(j0), 32'hC);
        chk("strm_k2", 32'(k0), 32'h3);
        chk("strm_done_clr", 32'(done0), 0);
        tgt0 = 4'b0101;
        tick();
        chk("strm_q2", 32'(q0), 32'hC);
        tgt0 = 4'b1010;
        tick();
        chk("strm_done2", 32'(done0), 1);
        vld0 = 1'b0;
        tick();
        chk("strm_idle_j", 32'(j0), 0);
        chk("strm_idle_q", 32'(q0), 32'hC);
        $display("txn dut0 streamed 0011,1100 q=%b", q0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
